// File: rtl/alu_pkg.sv
// Shared definitions for the sequential arithmetic unit: default widths,
// FSM state encodings, the flag bundle and the subtract-overflow rule.
package alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;
  localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
  localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic sign;
    logic borrow;
    logic zero;
    logic overflow;
  } flags_t;

  // Signed overflow of a - b: operands differ in sign and the result sign differs from a.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit ripple adder used for one slice of a + ~b + cin.
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b_inv,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign sum[i]    = a[i] ^ b_inv[i] ^ c_s[i];
    assign c_s[i+1]  = (a[i] & b_inv[i]) | (c_s[i] & (a[i] ^ b_inv[i]));
  end

  assign cout = c_s[SLICE];

endmodule

// File: rtl/seq_16bit_subtractor.sv
// Multi-cycle subtractor: one SLICE-bit slice of in1 + ~in2 + 1 per clock,
// LSB first, with results and flags published together on the done pulse.
module seq_16bit_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             sign,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  flags_t           flags_q, flags_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] a_slice_s, b_slice_s, sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] res_s;

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_slice_s),
    .b_inv (b_slice_s),
    .cin   (carry_q),
    .sum   (sum_s),
    .cout  (cout_s)
  );

  // Route the active slice to the adder and merge its sum into the accumulator view.
  always_comb begin
    a_slice_s = a_q[cnt_q*SLICE +: SLICE];
    b_slice_s = b_q[cnt_q*SLICE +: SLICE];
    res_s     = acc_q;
    res_s[cnt_q*SLICE +: SLICE] = sum_s;
  end

  // Next-state logic; b_q already holds ~in2, so in2's MSB is ~b_q[MSB].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = in1;
          b_d     = ~in2;
          carry_d = 1'b1;
          cnt_d   = {CW{1'b0}};
          acc_d   = {WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = res_s;
        carry_d = cout_s;
        cnt_d   = cnt_q + CW'(1'b1);
        if (cnt_q == CW'(NSL - 1)) begin
          state_d          = S_IDLE;
          cnt_d            = {CW{1'b0}};
          out_d            = res_s;
          flags_d.sign     = res_s[WIDTH-1];
          flags_d.borrow   = ~cout_s;
          flags_d.zero     = (res_s == {WIDTH{1'b0}});
          flags_d.overflow = sub_overflow(a_q[WIDTH-1], ~b_q[WIDTH-1], res_s[WIDTH-1]);
          done_d           = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      flags_q <= '{sign: 1'b0, borrow: 1'b0, zero: 1'b0, overflow: 1'b0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign out      = out_q;
  assign sign     = flags_q.sign;
  assign borrow   = flags_q.borrow;
  assign zero     = flags_q.zero;
  assign overflow = flags_q.overflow;

endmodule
